// File: rtl/cmd_arb_pkg.sv
// Shared types and constants for the UART/tour command arbiter.
// CMD_ARB_TIMEOUT_EN (see cmd_arbiter.sv) enables the EXECUTE watchdog.
package cmd_arb_pkg;

    localparam int unsigned CMD_W   = 16;
    localparam int unsigned TIMER_W = 24;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        EXECUTE = 2'd2
    } state_t;

    localparam logic OWN_UART = 1'b0;
    localparam logic OWN_TOUR = 1'b1;

    localparam logic [TIMER_W-1:0] TIMEOUT_CYC_DEF = 24'd1_000_000;

endpackage

// File: rtl/cmd_arb_timer.sv
// EXECUTE watchdog: counts enabled cycles since clr, flags the final cycle.
module cmd_arb_timer
    import cmd_arb_pkg::*;
#(
    parameter logic [TIMER_W-1:0] LIMIT = TIMEOUT_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + TIMER_W'(1);
        end
    end

    assign expired = en && (count == TIMER_W'(LIMIT - TIMER_W'(1)));

endmodule

// File: rtl/cmd_arbiter.sv
// Round-robin arbiter between UART and tour command sources feeding cmd_proc.
// Define CMD_ARB_TIMEOUT_EN to add an EXECUTE watchdog of TIMEOUT_CYC cycles.
module cmd_arbiter
    import cmd_arb_pkg::*;
#(
    parameter logic [TIMER_W-1:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CMD_W-1:0] uart_cmd,
    input  logic             uart_vld,
    output logic             uart_clr,
    output logic             uart_done,
    input  logic [CMD_W-1:0] tour_cmd,
    input  logic             tour_vld,
    output logic             tour_clr,
    output logic             tour_done,
    input  logic             tour_lock,
    output logic [CMD_W-1:0] cmd,
    output logic             cmd_rdy,
    input  logic             clr_cmd_rdy,
    input  logic             send_resp,
    output logic             owner,
    output logic             busy,
    output logic             timeout
);

    state_t state;
    logic   uart_elig;
    logic   tour_elig;
    logic   pick_tour;
    logic   clr_evt;
    logic   done_evt;
    logic   expired;

    // Tour wins when alone or when UART held the last grant.
    assign uart_elig = uart_vld && !tour_lock;
    assign tour_elig = tour_vld;
    assign pick_tour = tour_elig && (!uart_elig || (owner == OWN_UART));

    assign clr_evt  = (state == PRESENT) && clr_cmd_rdy;
    assign done_evt = (state == EXECUTE) && (send_resp || expired);

`ifdef CMD_ARB_TIMEOUT_EN
    cmd_arb_timer #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr_evt),
        .en      (state == EXECUTE),
        .expired (expired)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign expired            = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cmd     <= '0;
            cmd_rdy <= 1'b0;
            owner   <= OWN_TOUR;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (uart_elig || tour_elig) begin
                        state   <= PRESENT;
                        cmd     <= pick_tour ? tour_cmd : uart_cmd;
                        owner   <= pick_tour ? OWN_TOUR : OWN_UART;
                        cmd_rdy <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                PRESENT: begin
                    if (clr_cmd_rdy) begin
                        state   <= EXECUTE;
                        cmd_rdy <= 1'b0;
                    end
                end
                EXECUTE: begin
                    if (done_evt) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cmd_rdy <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Handshake pulses respond in the same cycle as cmd_proc's strobe.
    assign uart_clr  = clr_evt  && (owner == OWN_UART);
    assign tour_clr  = clr_evt  && (owner == OWN_TOUR);
    assign uart_done = done_evt && (owner == OWN_UART);
    assign tour_done = done_evt && (owner == OWN_TOUR);
    assign timeout   = (state == EXECUTE) && expired && !send_resp;

endmodule
